// File: rtl/dflow_tuple_sink.sv
// Receive end of the dflow tuple stream: counts packets/bytes, range-checks pkt_len and folds tuples into a signature.
// Optional feature macro DFLOW_SINK_BACKPRESSURE_EN adds LFSR-driven ready gating (CTRL bit2 = bp_enable).
`timescale 1ns/1ps
module dflow_tuple_sink #(
    parameter int PKT_TUPLE_WIDTH = 104,
    parameter int PKT_LEN_WIDTH   = 16,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PKT_TUPLE_WIDTH-1:0] fivetuple_in,
    input  logic [PKT_LEN_WIDTH-1:0]   pkt_len_in,
    input  logic                       tuple_in_vld,
    output logic                       tuple_in_ready,
    input  logic                       reg_req,
    input  logic                       reg_rd_wr_L,
    input  logic [31:0]                reg_addr,
    input  logic [31:0]                reg_wr_data,
    output logic                       reg_ack,
    output logic [31:0]                reg_rd_data,
    output logic                       done_irq,
    output logic [1:0]                 dbg_state
);
    // Handshake: a beat transfers on a rising edge where tuple_in_vld && tuple_in_ready;
    // vld may be held high while ready is low, nothing transfers then.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                   r_state;
    logic [CNT_WIDTH-1:0]     r_pkt_cnt;
    logic [CNT_WIDTH-1:0]     r_len_err_cnt;
    logic [CNT_WIDTH-1:0]     r_target;
    logic [63:0]              r_bytes;
    logic [31:0]              r_bytes_hi_snap;
    logic [31:0]              r_sig;
    logic [PKT_LEN_WIDTH-1:0] r_min_len;
    logic [PKT_LEN_WIDTH-1:0] r_max_len;
    logic                     r_len_err;
    logic                     r_ack;
    logic                     r_done_irq;
    logic [31:0]              r_rd_data;

    logic [3:0]               w_idx;
    logic                     w_wr;
    logic                     w_rd;
    logic                     w_start;
    logic                     w_clear;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_len_bad;
    logic                     w_hit;
    logic                     w_bp_en_rd;
    logic [CNT_WIDTH-1:0]     w_pkt_next;
    logic [127:0]             w_fold_in;
    logic [31:0]              w_sig_next;
    logic [31:0]              w_rd_mux;
    logic                     w_unused_addr;

    assign w_idx         = reg_addr[5:2];
    assign w_unused_addr = ^{reg_addr[31:6], reg_addr[1:0]};
    assign w_wr          = reg_req && !reg_rd_wr_L;
    assign w_rd          = reg_req && reg_rd_wr_L;
    assign w_start       = w_wr && (w_idx == 4'd0) && reg_wr_data[0];
    assign w_clear       = w_wr && (w_idx == 4'd0) && reg_wr_data[1];

`ifdef DFLOW_SINK_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic        r_bp_en;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr  <= 16'hACE1;
            r_bp_en <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            if (w_wr && (w_idx == 4'd0))
                r_bp_en <= reg_wr_data[2];
        end
    end

    assign w_ready    = (r_state == ST_RUN) && !(r_bp_en && (r_lfsr[2:0] == 3'd0));
    assign w_bp_en_rd = r_bp_en;
`else
    assign w_ready    = (r_state == ST_RUN);
    assign w_bp_en_rd = 1'b0;
`endif

    // A clear in the same cycle as a transfer drops that beat.
    assign w_accept   = tuple_in_vld && w_ready && !w_clear;
    assign w_pkt_next = r_pkt_cnt + CNT_WIDTH'(1);
    assign w_len_bad  = (pkt_len_in < r_min_len) || (pkt_len_in > r_max_len);
    assign w_hit      = (r_target != '0) && (w_pkt_next == r_target);
    assign w_fold_in  = {{(128 - PKT_TUPLE_WIDTH - PKT_LEN_WIDTH){1'b0}}, fivetuple_in, pkt_len_in};
    assign w_sig_next = {r_sig[30:0], r_sig[31]} ^ w_fold_in[31:0] ^ w_fold_in[63:32]
                        ^ w_fold_in[95:64] ^ w_fold_in[127:96];

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            4'd0: w_rd_mux = {29'd0, w_bp_en_rd, 2'b00};
            4'd1: w_rd_mux = 32'(r_target);
            4'd2: w_rd_mux = {29'd0, r_len_err, r_state == ST_DONE, r_state == ST_RUN};
            4'd3: w_rd_mux = 32'(r_pkt_cnt);
            4'd4: w_rd_mux = r_bytes[31:0];
            4'd5: w_rd_mux = r_bytes_hi_snap;
            4'd6: w_rd_mux = r_sig;
            4'd7: w_rd_mux = 32'(r_len_err_cnt);
            4'd8: w_rd_mux = 32'({r_max_len, r_min_len});
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_pkt_cnt       <= '0;
            r_len_err_cnt   <= '0;
            r_target        <= '0;
            r_bytes         <= '0;
            r_bytes_hi_snap <= '0;
            r_sig           <= '0;
            r_min_len       <= PKT_LEN_WIDTH'(64);
            r_max_len       <= PKT_LEN_WIDTH'(1518);
            r_len_err       <= 1'b0;
            r_ack           <= 1'b0;
            r_done_irq      <= 1'b0;
            r_rd_data       <= '0;
        end else begin
            r_done_irq <= 1'b0;
            if (w_clear) begin
                r_state         <= w_start ? ST_RUN : ST_IDLE;
                r_pkt_cnt       <= '0;
                r_len_err_cnt   <= '0;
                r_bytes         <= '0;
                r_bytes_hi_snap <= '0;
                r_sig           <= '0;
                r_len_err       <= 1'b0;
            end else begin
                if (w_start && (r_state != ST_RUN))
                    r_state <= ST_RUN;
                if (w_accept) begin
                    r_pkt_cnt <= w_pkt_next;
                    r_bytes   <= r_bytes + 64'(pkt_len_in);
                    r_sig     <= w_sig_next;
                    if (w_len_bad) begin
                        r_len_err_cnt <= r_len_err_cnt + CNT_WIDTH'(1);
                        r_len_err     <= 1'b1;
                    end
                    if (w_hit) begin
                        r_state    <= ST_DONE;
                        r_done_irq <= 1'b1;
                    end
                end
            end

            if (w_wr && (w_idx == 4'd1))
                r_target <= CNT_WIDTH'(reg_wr_data);
            if (w_wr && (w_idx == 4'd8)) begin
                r_min_len <= reg_wr_data[PKT_LEN_WIDTH-1:0];
                r_max_len <= reg_wr_data[16 +: PKT_LEN_WIDTH];
            end

            r_ack     <= reg_req;
            r_rd_data <= w_rd ? w_rd_mux : 32'd0;
            // Reading BYTES_LO freezes the upper half so a following BYTES_HI read is coherent.
            if (w_rd && (w_idx == 4'd4) && !w_clear)
                r_bytes_hi_snap <= r_bytes[63:32];
        end
    end

    assign tuple_in_ready = w_ready;
    assign reg_ack        = r_ack;
    assign reg_rd_data    = r_rd_data;
    assign done_irq       = r_done_irq;
    assign dbg_state      = r_state;

endmodule
